multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Next-generation RISC-V control unit. Replaces the single-cycle opcode decoder with a multi-cycle Moore FSM covering RV32I opcode classes.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Handshakes with instruction and data memory, detects illegal opcodes and memory timeouts, and counts retired instructions.
- Sits between the instruction register/memories and the datapath muxes, ALU control, register file and PC.

Parameters:
- ALU_OP_W, 3, width of alu_op; must be >= 3.
- TIMEOUT, 16, max cycles MEM waits for dmem_ready before a bus error; must be >= 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instruction_code  in  32  instruction word from imem; sampled only on fetch acceptance
- imem_ready  in  1  imem data valid this cycle
- dmem_ready  in  1  data memory access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- branch  out  1  conditional branch; PC updates only if ALU zero/compare is true (datapath gates it)
- jump  out  1  unconditional PC redirect (JAL/JALR)
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- MemtoReg  out  1  writeback selects memory data
- ALUSrc  out  1  ALU operand B = immediate
- RegWrite  out  1  register file write
- alu_op  out  ALU_OP_W  ALU operation class
- illegal  out  1  sticky: illegal opcode seen
- bus_error  out  1  sticky: data memory timeout
- halted  out  1  FSM in HALT
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: state=FETCH, latched opcode=0, timeout counter=0, instr_count=0. All outputs 0 except imem_req=1, which follows from the FETCH state.
- Outputs are Moore-style: decoded from the registered state and the latched 7-bit opcode only. There is no combinational path from instruction_code to any output.
- Opcode classes: R 0110011, IALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other value is ILLEGAL.
- alu_op encoding:
  - 000 add: LOAD, STORE, AUIPC, JAL, JALR
  - 001 compare: BRANCH
  - 010 R-type funct decode
  - 011 I-type funct decode
  - 100 pass-B: LUI
  - Upper bits beyond 3 are 0.
- ALUSrc=1 in EXEC for IALU, LOAD, STORE, JALR, LUI, AUIPC.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1, latch instruction_code[6:0], go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no control asserted. ILLEGAL -> HALT with illegal set; all other classes -> EXEC.
- EXEC: one cycle; ALUSrc and alu_op valid.
  - BRANCH: branch=1, then FETCH. The instruction retires here.
  - JAL/JALR: jump=1, pc_write=1, then WB (link write).
  - LOAD/STORE: go to MEM.
  - R/IALU/LUI/AUIPC: go to WB.
- MEM:
  - MemRead (LOAD) or MemWrite (STORE) held, with alu_op=000, ALUSrc=1.
  - The timeout counter increments each cycle without dmem_ready.
  - On dmem_ready: clear counter. LOAD -> WB; STORE -> FETCH (retires).
  - If the counter reaches TIMEOUT-1 without dmem_ready: set bus_error, go to HALT.
  - dmem_ready in the same cycle as the last allowed wait cycle counts as success.
- WB: one cycle, RegWrite=1. MemtoReg=1 only for LOAD. pc_write=1 for all except JAL/JALR, which already updated the PC in EXEC. Then FETCH; the instruction retires.
- HALT: all strobes 0, imem_req=0, halted=1. Exit only by reset.
- instr_count increments by 1 in the retire cycle and wraps modulo 2^CNT_W. Retire cycles: EXEC for BRANCH, MEM-with-ready for STORE, WB for all others.
- pc_write for sequential instructions is asserted in WB, so at most one PC update occurs per instruction.
- reset asserted in any state, including mid-MEM: returns to FETCH immediately, clears sticky flags, counter and instr_count. No strobe is asserted in the reset cycle.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ready on the first request -> states FETCH, DECODE, EXEC, WB. alu_op=010 in EXEC; RegWrite=1 and pc_write=1 in WB; instr_count=1 after 4 cycles.
- lw (0x0000A183), dmem_ready after 3 MEM cycles -> MemRead high for exactly 3 cycles, then WB with RegWrite=1, MemtoReg=1. Total 7 cycles.
- beq (0x00208463) -> EXEC with branch=1, alu_op=001, ALUSrc=0, pc_write=0. Back to FETCH after 3 cycles; instr_count +1.
- sw (0x0020A023) with TIMEOUT=4, dmem_ready never high -> MemWrite high for 4 cycles, then HALT with bus_error=1 and halted=1. imem_req stays 0 for 10 further cycles.
- Opcode 0x0000007F -> DECODE, then HALT with illegal=1 and no RegWrite/MemWrite. Pulsing reset returns to FETCH with illegal=0.
- CNT_W=4, run 17 addi instructions -> instr_count wraps 15 -> 0 -> 1. Asserting reset mid-MEM of a lw drops MemRead in the same cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction and data memory, flags illegal opcodes and data-memory timeouts.
module multicycle_control #(
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instruction_code,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                jump,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                ALUSrc,
    output logic                RegWrite,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                bus_error,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
    } class_t;

    typedef struct packed {
        logic       imem_req;
        logic       pc_write;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    function automatic class_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = C_R;
            7'b0010011: classify = C_IALU;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BRANCH;
            7'b1101111: classify = C_JAL;
            7'b1100111: classify = C_JALR;
            7'b0110111: classify = C_LUI;
            7'b0010111: classify = C_AUIPC;
            default:    classify = C_ILLEGAL;
        endcase
    endfunction

    // Control word for a given state/class; registered against the next state so the
    // outputs line up with the state register without any input-to-output path.
    function automatic ctrl_t ctrl_for(input state_t s, input class_t c);
        ctrl_t r;
        r = '0;
        case (s)
            S_FETCH: r.imem_req = 1'b1;
            S_EXEC: begin
                case (c)
                    C_BRANCH: r.alu_op = 3'b001;
                    C_R:      r.alu_op = 3'b010;
                    C_IALU:   r.alu_op = 3'b011;
                    C_LUI:    r.alu_op = 3'b100;
                    default:  r.alu_op = 3'b000;
                endcase
                r.alu_src = (c == C_IALU) || (c == C_LOAD) || (c == C_STORE) ||
                            (c == C_JALR) || (c == C_LUI)  || (c == C_AUIPC);
                r.branch   = (c == C_BRANCH);
                r.jump     = (c == C_JAL) || (c == C_JALR);
                r.pc_write = (c == C_JAL) || (c == C_JALR);
            end
            S_MEM: begin
                r.alu_src   = 1'b1;
                r.mem_read  = (c == C_LOAD);
                r.mem_write = (c == C_STORE);
            end
            S_WB: begin
                r.reg_write  = 1'b1;
                r.mem_to_reg = (c == C_LOAD);
                r.pc_write   = !((c == C_JAL) || (c == C_JALR));
            end
            S_HALT: r.halted = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t            state_reg, state_next;
    logic [6:0]        opcode_reg, opcode_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              illegal_reg, illegal_next;
    logic              bus_error_reg, bus_error_next;
    logic [CNT_W-1:0]  count_reg;
    logic              retire;
    ctrl_t             ctrl_reg;
    class_t            cls;
    logic              unused_instr_bits;

    assign cls               = classify(opcode_reg);
    assign unused_instr_bits = ^instruction_code[31:7];

    always_comb begin
        state_next     = state_reg;
        opcode_next    = opcode_reg;
        tmo_next       = tmo_reg;
        illegal_next   = illegal_reg;
        bus_error_next = bus_error_reg;
        retire         = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (imem_ready) begin
                    opcode_next = instruction_code[6:0];
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls == C_ILLEGAL) begin
                    illegal_next = 1'b1;
                    state_next   = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_BRANCH: begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                    C_LOAD, C_STORE: state_next = S_MEM;
                    default:         state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    tmo_next = '0;
                    if (cls == C_STORE) begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    tmo_next       = '0;
                    bus_error_next = 1'b1;
                    state_next     = S_HALT;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_FETCH;
            opcode_reg    <= '0;
            tmo_reg       <= '0;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
            count_reg     <= '0;
            ctrl_reg      <= ctrl_for(S_FETCH, C_ILLEGAL);
        end else begin
            state_reg     <= state_next;
            opcode_reg    <= opcode_next;
            tmo_reg       <= tmo_next;
            illegal_reg   <= illegal_next;
            bus_error_reg <= bus_error_next;
            if (retire) begin
                count_reg <= count_reg + 1'b1;
            end
            ctrl_reg      <= ctrl_for(state_next, classify(opcode_next));
        end
    end

    // The IR load strobe must coincide with imem data, so it is the one output qualified
    // by an input; reset masks it so no strobe fires while reset is held.
    assign ir_write    = (state_reg == S_FETCH) && imem_ready && !reset;
    assign imem_req    = ctrl_reg.imem_req;
    assign pc_write    = ctrl_reg.pc_write;
    assign branch      = ctrl_reg.branch;
    assign jump        = ctrl_reg.jump;
    assign MemRead     = ctrl_reg.mem_read;
    assign MemWrite    = ctrl_reg.mem_write;
    assign MemtoReg    = ctrl_reg.mem_to_reg;
    assign ALUSrc      = ctrl_reg.alu_src;
    assign RegWrite    = ctrl_reg.reg_write;
    assign alu_op      = ALU_OP_W'(ctrl_reg.alu_op);
    assign halted      = ctrl_reg.halted;
    assign illegal     = illegal_reg;
    assign bus_error   = bus_error_reg;
    assign instr_count = count_reg;

endmodule
